// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rtc_pkg
// Brief   : Shared BCD types, limits and legality helper for the RTC block.
// Revision: 1.0
// ============================================================================
package rtc_pkg;

    typedef logic [7:0] bcd_t;

    localparam bcd_t BCD_SEC_MAX = 8'h59;
    localparam bcd_t BCD_MIN_MAX = 8'h59;
    localparam bcd_t BCD_HR_MAX  = 8'h23;

    // Both nibbles must be decimal digits; once they are, byte order matches BCD order.
    function automatic logic bcd_legal(input bcd_t value, input bcd_t max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_time_counter_if.sv
`default_nettype none
// ============================================================================
// Module  : rtc_time_counter_if
// Brief   : Tick, load request and time/event outputs of the RTC counter.
// Revision: 1.0
// ============================================================================
interface rtc_time_counter_if;
    import rtc_pkg::*;

    logic one_hz;
    logic run;
    logic set_valid;
    bcd_t set_hh;
    bcd_t set_mm;
    bcd_t set_ss;
    bcd_t hh;
    bcd_t mm;
    bcd_t ss;
    logic set_ack;
    logic set_err;
    logic sec_pulse;
    logic day_pulse;

    modport master (
        output one_hz, run, set_valid, set_hh, set_mm, set_ss,
        input  hh, mm, ss, set_ack, set_err, sec_pulse, day_pulse
    );

    modport slave (
        input  one_hz, run, set_valid, set_hh, set_mm, set_ss,
        output hh, mm, ss, set_ack, set_err, sec_pulse, day_pulse
    );

endinterface
`default_nettype wire

// File: rtl/rtc_time_counter_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_mod_counter
// Brief   : Two-digit BCD counter wrapping at MAX, with synchronous load.
// Revision: 1.0
// ============================================================================
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter bcd_t MAX       = 8'h59,
    parameter bcd_t RESET_VAL = 8'h00
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic inc,
    input  wire logic load,
    input  wire bcd_t load_val,
    output bcd_t      value,
    output logic      carry
);

    bcd_t value_d;
    bcd_t value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (value_q == MAX) begin
                value_d = 8'h00;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MAX);

endmodule
`default_nettype wire

// File: rtl/rtc_time_counter.sv
`default_nettype none
// ============================================================================
// Module  : rtc_time_counter
// Brief   : BCD 24-hour HH:MM:SS counter with validated load and event pulses.
// Revision: 1.0
// ============================================================================
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter bcd_t INIT_HH = 8'h00,
    parameter bcd_t INIT_MM = 8'h00,
    parameter bcd_t INIT_SS = 8'h00
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rtc_time_counter_if.slave  bus
);

    logic w_set_legal;
    logic w_load_ok;
    logic w_advance;
    logic w_ss_carry;
    logic w_mm_carry;
    logic w_hh_carry;

    logic set_ack_d,   set_ack_q;
    logic set_err_d,   set_err_q;
    logic sec_pulse_d, sec_pulse_q;
    logic day_pulse_d, day_pulse_q;

    assign w_set_legal = bcd_legal(bus.set_ss, BCD_SEC_MAX)
                      && bcd_legal(bus.set_mm, BCD_MIN_MAX)
                      && bcd_legal(bus.set_hh, BCD_HR_MAX);
    assign w_load_ok   = bus.set_valid && w_set_legal;
    // An accepted load swallows a coincident tick; a rejected one does not.
    assign w_advance   = bus.one_hz && bus.run && !w_load_ok;

    bcd_mod_counter #(.MAX(BCD_SEC_MAX), .RESET_VAL(INIT_SS)) u_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_advance),
        .load     (w_load_ok),
        .load_val (bus.set_ss),
        .value    (bus.ss),
        .carry    (w_ss_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MIN_MAX), .RESET_VAL(INIT_MM)) u_mm (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_ss_carry),
        .load     (w_load_ok),
        .load_val (bus.set_mm),
        .value    (bus.mm),
        .carry    (w_mm_carry)
    );

    bcd_mod_counter #(.MAX(BCD_HR_MAX), .RESET_VAL(INIT_HH)) u_hh (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_mm_carry),
        .load     (w_load_ok),
        .load_val (bus.set_hh),
        .value    (bus.hh),
        .carry    (w_hh_carry)
    );

    always_comb begin
        set_ack_d   = w_load_ok;
        set_err_d   = bus.set_valid && !w_set_legal;
        sec_pulse_d = w_advance;
        day_pulse_d = w_hh_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            set_ack_q   <= set_ack_d;
            set_err_q   <= set_err_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign bus.set_ack   = set_ack_q;
    assign bus.set_err   = set_err_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_pulse = day_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rtc_time_counter
// Brief   : Self-checking bench; reference model keeps time as seconds-of-day.
// Revision: 1.0
// ============================================================================
module tb_rtc_time_counter;

    logic clk;
    logic rst_n;

    rtc_time_counter_if tif ();

    rtc_time_counter #(
        .INIT_HH (8'h00),
        .INIT_MM (8'h00),
        .INIT_SS (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    int tod;
    bit e_ack, e_err, e_sec, e_day;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic bit field_legal(input int v, input int max_dec);
        int hi;
        int lo;
        hi = v >> 4;
        lo = v & 15;
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= max_dec);
    endfunction

    function automatic int from_bcd(input int v);
        return (v >> 4) * 10 + (v & 15);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_hh"},  32'(tif.hh),        32'(to_bcd(tod / 3600)));
        check({tag, "_mm"},  32'(tif.mm),        32'(to_bcd((tod / 60) % 60)));
        check({tag, "_ss"},  32'(tif.ss),        32'(to_bcd(tod % 60)));
        check({tag, "_ack"}, 32'(tif.set_ack),   32'(e_ack));
        check({tag, "_err"}, 32'(tif.set_err),   32'(e_err));
        check({tag, "_sec"}, 32'(tif.sec_pulse), 32'(e_sec));
        check({tag, "_day"}, 32'(tif.day_pulse), 32'(e_day));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cyc(input string tag, input bit oh, input bit rn, input bit sv,
                       input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit legal;
        tif.one_hz    = oh;
        tif.run       = rn;
        tif.set_valid = sv;
        tif.set_hh    = h;
        tif.set_mm    = m;
        tif.set_ss    = s;
        @(posedge clk);
        legal = field_legal(h, 23) && field_legal(m, 59) && field_legal(s, 59);
        e_ack = sv && legal;
        e_err = sv && !legal;
        e_sec = 1'b0;
        e_day = 1'b0;
        if (e_ack) begin
            tod = from_bcd(h) * 3600 + from_bcd(m) * 60 + from_bcd(s);
        end else if (oh && rn) begin
            e_sec = 1'b1;
            e_day = (tod == 86399);
            tod   = (tod + 1) % 86400;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic tick(input string tag);
        cyc(tag, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic load(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
        cyc(tag, 1'b0, 1'b1, 1'b1, h, m, s);
    endtask

    initial begin
        logic [7:0] rh, rm, rs;
        checks = 0;
        errors = 0;
        tod    = 0;
        e_ack  = 0; e_err = 0; e_sec = 0; e_day = 0;

        rst_n         = 1'b0;
        tif.one_hz    = 1'b0;
        tif.run       = 1'b1;
        tif.set_valid = 1'b0;
        tif.set_hh    = 8'h00;
        tif.set_mm    = 8'h00;
        tif.set_ss    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset");

        load("ld_123458", 8'h12, 8'h34, 8'h58);
        tick("tick_59");
        tick("tick_min_carry");
        idle("after_ticks");

        load("ld_235959", 8'h23, 8'h59, 8'h59);
        tick("day_roll");
        idle("after_day");

        load("ld_010203", 8'h01, 8'h02, 8'h03);
        load("bad_ss", 8'h01, 8'h02, 8'h5A);
        load("bad_mm", 8'h01, 8'h60, 8'h03);
        load("bad_hh", 8'h24, 8'h02, 8'h03);
        load("bad_nib", 8'h0A, 8'h02, 8'h03);

        cyc("ld_win_tick", 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00);
        cyc("bad_with_tick", 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h60);
        cyc("held_ld_a", 1'b0, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07);
        cyc("held_ld_b", 1'b1, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07);

        load("ld_000007", 8'h00, 8'h00, 8'h07);
        for (int i = 0; i < 5; i++) begin
            cyc("frozen", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        cyc("frozen_ld", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h09);
        tick("run_again");
        idle("run_idle");

        load("ld_mid", 8'h07, 8'h08, 8'h09);
        tick("pre_rst_a");
        tick("pre_rst_b");
        rst_n = 1'b0;
        #1;
        tod = 0;
        e_ack = 0; e_err = 0; e_sec = 0; e_day = 0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_async");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rh = 8'(to_bcd($urandom_range(0, 23)));
                rm = 8'(to_bcd($urandom_range(0, 59)));
                rs = 8'(to_bcd($urandom_range(0, 59)));
                if ($urandom_range(0, 3) == 0) begin
                    rh = 8'h23;
                    rm = 8'h59;
                    rs = 8'(to_bcd($urandom_range(55, 59)));
                end
            end else begin
                rh = 8'($urandom);
                rm = 8'($urandom);
                rs = 8'($urandom);
            end
            cyc("rand",
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 15) == 0),
                rh, rm, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
